trap_ctrl: RTL and testbench

- Parametrised, registered trap controller for the CPU pipeline.
- Merges EXE-stage exception vectors, MEM-stage exception vectors and pending interrupts into a single prioritised trap request.
- Applies M→S delegation and holds a stable cause/epc/tval/target-privilege until the CSR/flush logic acknowledges.
- Sits between the decode/LSU fault sources and the CSR file; adds interrupt arbitration, delegation and a request/ack handshake that the previous combinational trap unit lacked.

---
 rtl/trap_ctrl.sv | 156 +++++++++++++++
 tb/tb_trap_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Registered trap controller: prioritises MEM/EXE exceptions and enabled interrupts,
// applies M->S delegation, and holds the selected trap until the CSR/flush logic acks.
module trap_ctrl #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 32,
  parameter int N_EXC    = 16,
  parameter int INT_NUM  = 12,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                exe_valid,
  input  logic [N_EXC-1:0]    exe_exc,
  input  logic [ADDR_LEN-1:0] exe_pc,
  input  logic [31:0]         exe_inst,
  input  logic [N_EXC-1:0]    mem_exc,
  input  logic [ADDR_LEN-1:0] mem_pc,
  input  logic [ADDR_LEN-1:0] mem_addr,
  input  logic [INT_NUM-1:0]  irq_pend,
  input  logic [1:0]          prv_cur,
  input  logic                mstatus_mie,
  input  logic                mstatus_sie,
  input  logic [N_EXC-1:0]    medeleg,
  input  logic [INT_NUM-1:0]  mideleg,
  output logic                trap_req,
  input  logic                trap_ack,
  output logic [XLEN-1:0]     trap_cause,
  output logic [ADDR_LEN-1:0] trap_epc,
  output logic [XLEN-1:0]     trap_val,
  output logic [1:0]          trap_prv,
  output logic                busy,
  output logic [CNT_W-1:0]    trap_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_e;

  localparam int MEM_N = 6;
  localparam int EXE_N = 8;
  localparam int IRQ_N = 6;
  localparam int MEM_ORD [MEM_N] = '{6, 4, 15, 13, 7, 5};
  localparam int EXE_ORD [EXE_N] = '{3, 12, 1, 2, 0, 8, 9, 11};
  localparam int IRQ_ORD [IRQ_N] = '{11, 3, 7, 9, 1, 5};

  state_e              state_q, state_d;
  logic [XLEN-1:0]     cause_q, cause_d;
  logic [ADDR_LEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0]     val_q, val_d;
  logic [1:0]          prv_q, prv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                mem_hit, exe_hit, irq_hit;
  int                  mem_idx, exe_idx, irq_idx;
  logic [INT_NUM-1:0]  irq_en;

  // Per-line enable: delegated lines target S and are masked while in M.
  always_comb begin
    irq_en = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      if (mideleg[i])
        irq_en[i] = irq_pend[i] & ((prv_cur == 2'd0) | ((prv_cur == 2'd1) & mstatus_sie));
      else
        irq_en[i] = irq_pend[i] & ((prv_cur != 2'd3) | mstatus_mie);
    end
  end

  // Fallback pass picks the lowest set index; the fixed-order pass then overrides it.
  always_comb begin
    mem_hit = |mem_exc;
    exe_hit = |exe_exc;
    irq_hit = |irq_en;
    mem_idx = 0;
    exe_idx = 0;
    irq_idx = 0;
    for (int i = N_EXC-1; i >= 0; i--) begin
      if (mem_exc[i]) mem_idx = i;
      if (exe_exc[i]) exe_idx = i;
    end
    for (int i = INT_NUM-1; i >= 0; i--)
      if (irq_en[i]) irq_idx = i;
    for (int k = MEM_N-1; k >= 0; k--)
      if (MEM_ORD[k] < N_EXC && mem_exc[MEM_ORD[k]]) mem_idx = MEM_ORD[k];
    for (int k = EXE_N-1; k >= 0; k--)
      if (EXE_ORD[k] < N_EXC && exe_exc[EXE_ORD[k]]) exe_idx = EXE_ORD[k];
    for (int k = IRQ_N-1; k >= 0; k--)
      if (IRQ_ORD[k] < INT_NUM && irq_en[IRQ_ORD[k]]) irq_idx = IRQ_ORD[k];
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    val_d   = val_q;
    prv_d   = prv_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_hit) begin
          state_d = REQ;
          cause_d = XLEN'(mem_idx);
          epc_d   = mem_pc;
          val_d   = XLEN'(mem_addr);
          prv_d   = (medeleg[mem_idx] && prv_cur != 2'd3) ? 2'd1 : 2'd3;
        end else if (exe_valid && exe_hit) begin
          state_d = REQ;
          cause_d = XLEN'(exe_idx);
          epc_d   = exe_pc;
          if (exe_idx == 12 || exe_idx == 1) val_d = XLEN'(exe_pc);
          else if (exe_idx == 2)              val_d = XLEN'(exe_inst);
          else                                val_d = '0;
          prv_d   = (medeleg[exe_idx] && prv_cur != 2'd3) ? 2'd1 : 2'd3;
        end else if (exe_valid && irq_hit) begin
          state_d = REQ;
          cause_d = {1'b1, (XLEN-1)'(irq_idx)};
          epc_d   = exe_pc;
          val_d   = '0;
          prv_d   = mideleg[irq_idx] ? 2'd1 : 2'd3;
        end
      end
      REQ: begin
        if (trap_ack) begin
          state_d = FLUSH;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      val_q   <= '0;
      prv_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      val_q   <= val_d;
      prv_q   <= prv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign trap_req   = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign trap_cause = cause_q;
  assign trap_epc   = epc_q;
  assign trap_val   = val_q;
  assign trap_prv   = prv_q;
  assign trap_cnt   = cnt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; a 3-bit counter lets saturation be reached in a few traps.
module tb_trap_ctrl;
  logic        clk, rstn;
  logic        exe_valid;
  logic [15:0] exe_exc, mem_exc, medeleg;
  logic [31:0] exe_pc, exe_inst, mem_pc, mem_addr;
  logic [11:0] irq_pend, mideleg;
  logic [1:0]  prv_cur;
  logic        mstatus_mie, mstatus_sie;
  logic        trap_req, trap_ack, busy;
  logic [31:0] trap_cause, trap_epc, trap_val;
  logic [1:0]  trap_prv;
  logic [2:0]  trap_cnt;
  int pass_cnt = 0;
  int tot_cnt  = 0;

  trap_ctrl #(.XLEN(32), .ADDR_LEN(32), .N_EXC(16), .INT_NUM(12), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn), .exe_valid(exe_valid), .exe_exc(exe_exc), .exe_pc(exe_pc),
    .exe_inst(exe_inst), .mem_exc(mem_exc), .mem_pc(mem_pc), .mem_addr(mem_addr),
    .irq_pend(irq_pend), .prv_cur(prv_cur), .mstatus_mie(mstatus_mie),
    .mstatus_sie(mstatus_sie), .medeleg(medeleg), .mideleg(mideleg),
    .trap_req(trap_req), .trap_ack(trap_ack), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_val(trap_val), .trap_prv(trap_prv), .busy(busy),
    .trap_cnt(trap_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr;
    exe_valid = 1'b0; exe_exc = '0; mem_exc = '0; irq_pend = '0; trap_ack = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; clr();
    exe_pc = '0; exe_inst = '0; mem_pc = '0; mem_addr = '0;
    prv_cur = 2'd3; mstatus_mie = 1'b0; mstatus_sie = 1'b0; medeleg = '0; mideleg = '0;
    step(); step();
    tot_cnt++; if (trap_req !== 1'b0) $display("FAIL rst_req got %b exp 0", trap_req); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
    tot_cnt++; if ({trap_cause, trap_epc, trap_val} !== 96'd0)
      $display("FAIL rst_regs got %h %h %h exp 0", trap_cause, trap_epc, trap_val); else pass_cnt++;
    tot_cnt++; if (trap_prv !== 2'd3) $display("FAIL rst_prv got %0d exp 3", trap_prv); else pass_cnt++;
    tot_cnt++; if (trap_cnt !== 3'd0) $display("FAIL rst_cnt got %0d exp 0", trap_cnt); else pass_cnt++;
    @(negedge clk); rstn = 1'b1;
    step();
  endtask

  task automatic test_exe_illegal;
    exe_valid = 1'b1; exe_exc = 16'h0004; exe_inst = 32'hFFFF_FFFF; exe_pc = 32'h0000_0100;
    tot_cnt++; if (trap_req !== 1'b0) $display("FAIL ill_req_early got %b exp 0", trap_req); else pass_cnt++;
    step(); clr();
    tot_cnt++; if (trap_req !== 1'b1) $display("FAIL ill_req got %b exp 1", trap_req); else pass_cnt++;
    tot_cnt++; if (trap_cause !== 32'd2) $display("FAIL ill_cause got %h exp 2", trap_cause); else pass_cnt++;
    tot_cnt++; if (trap_val !== 32'hFFFF_FFFF) $display("FAIL ill_val got %h exp ffffffff", trap_val); else pass_cnt++;
    tot_cnt++; if (trap_epc !== 32'h100) $display("FAIL ill_epc got %h exp 100", trap_epc); else pass_cnt++;
    tot_cnt++; if (trap_prv !== 2'd3) $display("FAIL ill_prv got %0d exp 3", trap_prv); else pass_cnt++;
    trap_ack = 1'b1; step(); trap_ack = 1'b0;
    tot_cnt++; if ({busy, trap_req} !== 2'b10) $display("FAIL ill_flush got busy=%b req=%b exp 1 0", busy, trap_req); else pass_cnt++;
    step();
    tot_cnt++; if (busy !== 1'b0) $display("FAIL ill_idle got %b exp 0", busy); else pass_cnt++;
    tot_cnt++; if (trap_cnt !== 3'd1) $display("FAIL ill_cnt got %0d exp 1", trap_cnt); else pass_cnt++;
    tot_cnt++; if (trap_cause !== 32'd2) $display("FAIL ill_cause_kept got %h exp 2", trap_cause); else pass_cnt++;
  endtask

  task automatic test_mem_priority;
    mem_exc = 16'h2000; mem_addr = 32'h8000_1004; mem_pc = 32'h0000_0200;
    exe_valid = 1'b1; exe_exc = 16'h0100; exe_pc = 32'h0000_0300;
    step(); clr();
    tot_cnt++; if (trap_cause !== 32'd13) $display("FAIL mem_cause got %h exp d", trap_cause); else pass_cnt++;
    tot_cnt++; if (trap_val !== 32'h8000_1004) $display("FAIL mem_val got %h exp 80001004", trap_val); else pass_cnt++;
    tot_cnt++; if (trap_epc !== 32'h200) $display("FAIL mem_epc got %h exp 200", trap_epc); else pass_cnt++;
    trap_ack = 1'b1; step(); trap_ack = 1'b0; step();
    tot_cnt++; if (trap_cnt !== 3'd2) $display("FAIL mem_cnt got %0d exp 2", trap_cnt); else pass_cnt++;
  endtask

  task automatic test_deleg;
    prv_cur = 2'd0; medeleg = 16'h0100;
    exe_valid = 1'b1; exe_exc = 16'h0100; exe_pc = 32'h400;
    step(); clr();
    tot_cnt++; if (trap_cause !== 32'd8) $display("FAIL deleg_cause got %h exp 8", trap_cause); else pass_cnt++;
    tot_cnt++; if (trap_prv !== 2'd1) $display("FAIL deleg_prv_u got %0d exp 1", trap_prv); else pass_cnt++;
    tot_cnt++; if (trap_val !== 32'd0) $display("FAIL deleg_val got %h exp 0", trap_val); else pass_cnt++;
    trap_ack = 1'b1; step(); trap_ack = 1'b0; step();
    prv_cur = 2'd3; exe_valid = 1'b1; exe_exc = 16'h0100;
    step(); clr();
    tot_cnt++; if (trap_prv !== 2'd3) $display("FAIL deleg_prv_m got %0d exp 3", trap_prv); else pass_cnt++;
    trap_ack = 1'b1; step(); trap_ack = 1'b0; step();
    tot_cnt++; if (trap_cnt !== 3'd4) $display("FAIL deleg_cnt got %0d exp 4", trap_cnt); else pass_cnt++;
  endtask

  task automatic test_irq;
    prv_cur = 2'd3; mstatus_mie = 1'b0; mideleg = '0; medeleg = '0;
    exe_valid = 1'b1; irq_pend = 12'h880; exe_pc = 32'h500;
    step(); step();
    tot_cnt++; if ({trap_req, busy} !== 2'b00) $display("FAIL irq_masked got req=%b busy=%b exp 0 0", trap_req, busy); else pass_cnt++;
    mstatus_mie = 1'b1;
    step(); clr();
    tot_cnt++; if (trap_cause !== 32'h8000_000B) $display("FAIL irq_cause got %h exp 8000000b", trap_cause); else pass_cnt++;
    tot_cnt++; if (trap_val !== 32'd0) $display("FAIL irq_val got %h exp 0", trap_val); else pass_cnt++;
    tot_cnt++; if (trap_epc !== 32'h500) $display("FAIL irq_epc got %h exp 500", trap_epc); else pass_cnt++;
    trap_ack = 1'b1; step(); trap_ack = 1'b0; step();
  endtask

  task automatic test_exe_order;
    exe_valid = 1'b1; exe_exc = 16'h1003; exe_pc = 32'h700; irq_pend = 12'hFFF;
    step(); clr();
    tot_cnt++; if (trap_cause !== 32'd12) $display("FAIL ord_cause got %h exp c", trap_cause); else pass_cnt++;
    tot_cnt++; if (trap_val !== 32'h700) $display("FAIL ord_val got %h exp 700", trap_val); else pass_cnt++;
    trap_ack = 1'b1; step(); trap_ack = 1'b0; step();
    tot_cnt++; if (trap_cnt !== 3'd6) $display("FAIL ord_cnt got %0d exp 6", trap_cnt); else pass_cnt++;
  endtask

  task automatic test_hold_ack;
    exe_valid = 1'b1; exe_exc = 16'h0008; exe_pc = 32'h600;
    step();
    for (int i = 0; i < 5; i++) begin
      exe_valid = i[0]; exe_exc = 16'hFFFF; mem_exc = 16'h2050 << i[1:0];
      irq_pend = 12'hFFF; exe_pc = 32'h1000 + i; mem_pc = 32'h2000 + i;
      step();
      tot_cnt++;
      if ({trap_req, trap_cause, trap_epc, trap_val, trap_prv} !== {1'b1, 32'd3, 32'h600, 32'd0, 2'd3})
        $display("FAIL hold_%0d got req=%b cause=%h epc=%h val=%h prv=%0d exp 1 3 600 0 3",
                 i, trap_req, trap_cause, trap_epc, trap_val, trap_prv);
      else pass_cnt++;
    end
    clr(); trap_ack = 1'b1; step(); trap_ack = 1'b0;
    tot_cnt++; if ({busy, trap_req} !== 2'b10) $display("FAIL hold_flush got busy=%b req=%b exp 1 0", busy, trap_req); else pass_cnt++;
    step();
    tot_cnt++; if (busy !== 1'b0) $display("FAIL hold_idle got %b exp 0", busy); else pass_cnt++;
    tot_cnt++; if (trap_cnt !== 3'd7) $display("FAIL hold_cnt got %0d exp 7", trap_cnt); else pass_cnt++;
  endtask

  task automatic test_saturate;
    exe_valid = 1'b1; exe_exc = 16'h0001; exe_pc = 32'h800;
    step(); clr();
    tot_cnt++; if (trap_req !== 1'b1) $display("FAIL sat_req got %b exp 1", trap_req); else pass_cnt++;
    trap_ack = 1'b1; step(); trap_ack = 1'b0; step();
    tot_cnt++; if (trap_cnt !== 3'd7) $display("FAIL sat_cnt got %0d exp 7", trap_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req;
    rstn = 1'b0; step();
    @(negedge clk); rstn = 1'b1; step();
    exe_valid = 1'b1; exe_exc = 16'h0004; exe_pc = 32'h900; exe_inst = 32'h1234_5678;
    step(); clr();
    tot_cnt++; if (trap_req !== 1'b1) $display("FAIL mid_req_pre got %b exp 1", trap_req); else pass_cnt++;
    #2 rstn = 1'b0; #1;
    tot_cnt++; if ({trap_req, busy} !== 2'b00) $display("FAIL mid_req_rst got req=%b busy=%b exp 0 0", trap_req, busy); else pass_cnt++;
    tot_cnt++; if (trap_cnt !== 3'd0) $display("FAIL mid_req_cnt got %0d exp 0", trap_cnt); else pass_cnt++;
    @(negedge clk); rstn = 1'b1;
    step(); step();
    tot_cnt++; if ({busy, trap_cnt} !== 4'b0000) $display("FAIL mid_req_after got busy=%b cnt=%0d exp 0 0", busy, trap_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_exe_illegal();
    test_mem_priority();
    test_deleg();
    test_irq();
    test_exe_order();
    test_hold_ack();
    test_saturate();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
